// File: rtl/flash_audio_pkg.sv
// Shared types and default constants for the flash audio playback path.
package flash_audio_pkg;

    localparam int ADDR_W_DEF   = 23;
    localparam int SAMPLE_W_DEF = 16;
    localparam int DATA_W_DEF   = 2 * SAMPLE_W_DEF;

    localparam logic [ADDR_W_DEF-1:0] SONG_START = 23'h000000;
    localparam logic [ADDR_W_DEF-1:0] SONG_END   = 23'h07FFFF;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_REQ       = 4'd1,
        ST_WAIT_DATA = 4'd2,
        ST_TICK_A    = 4'd3,
        ST_TICK_B    = 4'd4,
        ST_DONE      = 4'd5
    } seq_state_t;

endpackage

// File: rtl/flash_range_counter.sv
// Up/down word-address counter bounded to [START_ADDR, END_ADDR] with load and optional wrap.
module flash_range_counter #(
    parameter int                ADDR_W     = 23,
    parameter logic [ADDR_W-1:0] START_ADDR = '0,
    parameter logic [ADDR_W-1:0] END_ADDR   = '1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              load_dir,
    input  logic              step,
    input  logic              dir,
    input  logic              wrap_en,
    output logic [ADDR_W-1:0] count,
    output logic              at_end
);

    // "End" is the bound we are moving towards, so it follows the direction.
    assign at_end = dir ? (count == START_ADDR) : (count == END_ADDR);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= START_ADDR;
        end else if (load) begin
            count <= load_dir ? END_ADDR : START_ADDR;
        end else if (step) begin
            if (at_end) begin
                if (wrap_en)
                    count <= dir ? END_ADDR : START_ADDR;
            end else begin
                count <= dir ? count - ADDR_W'(1) : count + ADDR_W'(1);
            end
        end
    end

endmodule

// File: rtl/flash_addr_sequencer.sv
// Fetches 32-bit flash words over Avalon-MM and plays them out as two 16-bit samples per word.
module flash_addr_sequencer
    import flash_audio_pkg::*;
#(
    parameter int                ADDR_W     = ADDR_W_DEF,
    parameter int                DATA_W     = DATA_W_DEF,
    parameter int                SAMPLE_W   = SAMPLE_W_DEF,
    parameter logic [ADDR_W-1:0] START_ADDR = ADDR_W'(SONG_START),
    parameter logic [ADDR_W-1:0] END_ADDR   = ADDR_W'(SONG_END)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                play,
    input  logic                dir,
    input  logic                restart,
    input  logic                loop_en,
    input  logic                sample_tick,
    output logic                flash_read,
    output logic [ADDR_W-1:0]   flash_address,
    input  logic                flash_waitrequest,
    input  logic                flash_readdatavalid,
    input  logic [DATA_W-1:0]   flash_readdata,
    output logic [SAMPLE_W-1:0] sample_out,
    output logic                sample_valid,
    output logic                underrun,
    output logic                done,
    output logic [3:0]          state
);

    seq_state_t          state_q, state_d;
    logic                restart_pending;
    logic [DATA_W-1:0]   word_q;
    logic                word_dir;
    logic                at_end;
    logic                tick_play, discard;
    logic                take_a, take_b, reload, underrun_d;

    function automatic logic [SAMPLE_W-1:0] pick_half(input logic [DATA_W-1:0] w,
                                                      input logic upper);
        return upper ? w[DATA_W-1 -: SAMPLE_W] : w[SAMPLE_W-1:0];
    endfunction

    assign tick_play = sample_tick & play;
    // A restart seen during the bus transaction (or on its final beat) throws the word away.
    assign discard   = restart_pending | restart;
    assign state     = state_q;

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (restart) state_d = ST_IDLE;
                          else if (play) state_d = ST_REQ;
            ST_REQ:       if (!flash_waitrequest) state_d = ST_WAIT_DATA;
            ST_WAIT_DATA: if (flash_readdatavalid) state_d = discard ? ST_IDLE : ST_TICK_A;
            ST_TICK_A:    if (restart) state_d = ST_IDLE;
                          else if (tick_play) state_d = ST_TICK_B;
            ST_TICK_B:    if (restart) state_d = ST_IDLE;
                          else if (tick_play) state_d = (at_end && !loop_en) ? ST_DONE : ST_IDLE;
            ST_DONE:      if (restart) state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        flash_read = (state_q == ST_REQ);
        done       = (state_q == ST_DONE);
        take_a     = (state_q == ST_TICK_A) && tick_play && !restart;
        take_b     = (state_q == ST_TICK_B) && tick_play && !restart;
        reload     = (restart && (state_q == ST_IDLE || state_q == ST_TICK_A ||
                                  state_q == ST_TICK_B || state_q == ST_DONE)) ||
                     (state_q == ST_WAIT_DATA && flash_readdatavalid && discard);
        underrun_d = tick_play && (state_q == ST_IDLE || state_q == ST_REQ ||
                                   state_q == ST_WAIT_DATA);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word_q          <= '0;
            word_dir        <= 1'b0;
            sample_out      <= '0;
            sample_valid    <= 1'b0;
            underrun        <= 1'b0;
            restart_pending <= 1'b0;
        end else begin
            sample_valid <= take_a | take_b;
            underrun     <= underrun_d;
            if (state_q == ST_WAIT_DATA && flash_readdatavalid && !discard) begin
                word_q   <= flash_readdata;
                word_dir <= dir;
            end
            // Half order is fixed per word by the direction in force when it arrived.
            if (take_a) sample_out <= pick_half(word_q, word_dir);
            if (take_b) sample_out <= pick_half(word_q, !word_dir);
            if (reload)
                restart_pending <= 1'b0;
            else if (restart && (state_q == ST_REQ || state_q == ST_WAIT_DATA))
                restart_pending <= 1'b1;
        end
    end

    flash_range_counter #(
        .ADDR_W     (ADDR_W),
        .START_ADDR (START_ADDR),
        .END_ADDR   (END_ADDR)
    ) u_addr (
        .clk      (clk),
        .rst      (rst),
        .load     (reload),
        .load_dir (dir),
        .step     (take_b),
        .dir      (dir),
        .wrap_en  (loop_en),
        .count    (flash_address),
        .at_end   (at_end)
    );

endmodule

// File: tb/tb_flash_addr_sequencer.sv
// Directed bench for flash_addr_sequencer with a sample scoreboard.
module tb_flash_addr_sequencer;

    localparam logic [22:0] S_ADDR = 23'h000000;
    localparam logic [22:0] E_ADDR = 23'h07FFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1, play = 1'b0, dir = 1'b0, restart = 1'b0, loop_en = 1'b1;
    logic        sample_tick = 1'b0, wr = 1'b1, rdv = 1'b0;
    logic [31:0] rd = '0;
    logic        flash_read, sample_valid, underrun, done;
    logic [22:0] flash_address;
    logic [15:0] sample_out;
    logic [3:0]  state;

    int checks = 0, errors = 0;
    int read_cycles = 0, underrun_cnt = 0;
    logic [15:0] got_q[$];
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    flash_addr_sequencer dut (
        .clk                 (clk),
        .rst                 (rst),
        .play                (play),
        .dir                 (dir),
        .restart             (restart),
        .loop_en             (loop_en),
        .sample_tick         (sample_tick),
        .flash_read          (flash_read),
        .flash_address       (flash_address),
        .flash_waitrequest   (wr),
        .flash_readdatavalid (rdv),
        .flash_readdata      (rd),
        .sample_out          (sample_out),
        .sample_valid        (sample_valid),
        .underrun            (underrun),
        .done                (done),
        .state               (state)
    );

    always @(negedge clk) begin
        if (sample_valid) got_q.push_back(sample_out);
        if (flash_read)   read_cycles++;
        if (underrun)     underrun_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
    endtask

    task automatic wait_req();
        for (int i = 0; i < 50 && !flash_read; i++) step();
        check("req_seen", {31'd0, flash_read}, 32'd1);
    endtask

    task automatic fetch(input int waits, input logic [31:0] data);
        for (int i = 0; i < waits; i++) step();
        wr = 1'b0;
        step();
        wr  = 1'b1;
        rdv = 1'b1;
        rd  = data;
        step();
        rdv = 1'b0;
        rd  = '0;
    endtask

    task automatic check_samples();
        logic [15:0] g, e;
        @(negedge clk);
        #1;
        while (got_q.size() > 0) begin
            g = got_q.pop_front();
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sample", {16'd0, g}, {16'd0, e});
            end else begin
                check("sample_unexpected", {16'd0, g}, 32'hFFFF_FFFF);
            end
        end
        check("samples_missing", exp_q.size(), 0);
    endtask

    initial begin
        int r0, u0;
        repeat (2) step();
        check("rst_state", {28'd0, state}, 32'd0);
        check("rst_addr", {9'd0, flash_address}, {9'd0, S_ADDR});
        check("rst_read", {31'd0, flash_read}, 32'd0);
        check("rst_sample", {16'd0, sample_out}, 32'd0);
        check("rst_flags", {29'd0, sample_valid, underrun, done}, 32'd0);
        rst = 1'b0;

        // forward word with three wait states
        play = 1'b1;
        wait_req();
        r0 = read_cycles;
        check("req0_addr", {9'd0, flash_address}, 32'd0);
        fetch(3, 32'hBEEF_1234);
        check("req0_cycles", read_cycles - r0, 4);
        check("tick_a_state", {28'd0, state}, 32'd3);
        exp_q.push_back(16'h1234);
        exp_q.push_back(16'hBEEF);
        tick();
        tick();
        check_samples();
        wait_req();
        check("req1_addr", {9'd0, flash_address}, 32'd1);

        // tick during REQ is dropped and flagged
        tick();
        check("underrun_pulse", {31'd0, underrun}, 32'd1);
        check("underrun_hold", {16'd0, sample_out}, 32'h0000_BEEF);
        step();
        check("underrun_one", {31'd0, underrun}, 32'd0);

        // restart during WAIT_DATA discards the word
        wr = 1'b0;
        step();
        wr = 1'b1;
        check("wait_state", {28'd0, state}, 32'd2);
        restart = 1'b1;
        step();
        restart = 1'b0;
        check("pending_wait", {28'd0, state}, 32'd2);
        rdv = 1'b1;
        rd  = 32'h1111_2222;
        step();
        rdv = 1'b0;
        rd  = '0;
        check("discard_state", {28'd0, state}, 32'd0);
        check_samples();
        wait_req();
        check("restart_addr", {9'd0, flash_address}, {9'd0, S_ADDR});

        // pause in TICK_A: ticks ignored
        fetch(1, 32'h1357_2468);
        u0 = underrun_cnt;
        play = 1'b0;
        repeat (5) begin
            tick();
            step();
        end
        check("pause_state", {28'd0, state}, 32'd3);
        check("pause_underrun", underrun_cnt - u0, 0);
        check_samples();
        play = 1'b1;
        exp_q.push_back(16'h2468);
        tick();
        // restart together with the TICK_B advance tick: restart wins
        dir = 1'b1;
        restart = 1'b1;
        sample_tick = 1'b1;
        step();
        restart = 1'b0;
        sample_tick = 1'b0;
        check("rw_valid", {31'd0, sample_valid}, 32'd0);
        check("rw_state", {28'd0, state}, 32'd0);
        check("rw_addr", {9'd0, flash_address}, {9'd0, E_ADDR});
        check_samples();

        // backward word from range end
        wait_req();
        check("bwd_addr", {9'd0, flash_address}, {9'd0, E_ADDR});
        fetch(0, 32'hAAAA_5555);
        exp_q.push_back(16'hAAAA);
        exp_q.push_back(16'h5555);
        tick();
        tick();
        play = 1'b0;
        check("bwd_next", {9'd0, flash_address}, 32'h0007_FFFE);
        check_samples();

        // forward at END_ADDR with wrap
        restart = 1'b1;
        step();
        restart = 1'b0;
        dir = 1'b0;
        play = 1'b1;
        wait_req();
        check("end_addr", {9'd0, flash_address}, {9'd0, E_ADDR});
        fetch(2, 32'h5A5A_C3C3);
        exp_q.push_back(16'hC3C3);
        exp_q.push_back(16'h5A5A);
        tick();
        tick();
        play = 1'b0;
        check("wrap_addr", {9'd0, flash_address}, {9'd0, S_ADDR});
        check("wrap_state", {28'd0, state}, 32'd0);
        check_samples();

        // forward at END_ADDR without wrap -> DONE
        dir = 1'b1;
        restart = 1'b1;
        step();
        restart = 1'b0;
        dir = 1'b0;
        loop_en = 1'b0;
        play = 1'b1;
        wait_req();
        fetch(0, 32'h0F0F_F0F0);
        exp_q.push_back(16'hF0F0);
        exp_q.push_back(16'h0F0F);
        tick();
        tick();
        check("done_state", {28'd0, state}, 32'd5);
        check("done_flag", {31'd0, done}, 32'd1);
        check("done_addr", {9'd0, flash_address}, {9'd0, E_ADDR});
        check_samples();
        r0 = read_cycles;
        u0 = underrun_cnt;
        repeat (4) begin
            tick();
            step();
        end
        check("done_noread", read_cycles - r0, 0);
        check("done_nounder", underrun_cnt - u0, 0);
        check("done_hold", {16'd0, sample_out}, 32'h0000_0F0F);
        check("done_stay", {31'd0, done}, 32'd1);
        check_samples();

        // restart leaves DONE, then reset during REQ
        restart = 1'b1;
        step();
        restart = 1'b0;
        check("exit_done", {28'd0, state}, 32'd0);
        check("exit_addr", {9'd0, flash_address}, {9'd0, S_ADDR});
        wait_req();
        rst = 1'b1;
        step();
        rst = 1'b0;
        play = 1'b0;
        check("rreq_read", {31'd0, flash_read}, 32'd0);
        check("rreq_state", {28'd0, state}, 32'd0);
        check("rreq_addr", {9'd0, flash_address}, {9'd0, S_ADDR});
        check("rreq_sample", {16'd0, sample_out}, 32'd0);
        check("rreq_flags", {29'd0, sample_valid, underrun, done}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/flash_addr_sequencer.md
Name: flash_addr_sequencer

Overview:
- Parametrised flash read-address sequencer for the audio playback path.
- Fetches 32-bit words from flash over an Avalon-MM read handshake and splits each word into two 16-bit samples.
- Presents one sample per sample_tick.
- Supports play/pause, forward/backward direction, restart, and loop/stop at range end.
- Sits between the keyboard control decoder and the audio output.

Parameters:
ADDR_W, 23, flash word-address width
DATA_W, 32, flash read-data width; must equal 2*SAMPLE_W
SAMPLE_W, 16, audio sample width
START_ADDR, 23'h000000, first word address of the playback range
END_ADDR, 23'h07FFFF, last word address of the playback range; must be >= START_ADDR

Ports:
clk  in  1  system clock; the only clock
rst  in  1  synchronous active-high reset
play  in  1  level; 1 = play, 0 = pause
dir  in  1  0 = forward (incrementing), 1 = backward (decrementing)
restart  in  1  one-cycle pulse; jump to range start (fwd) or range end (bwd)
loop_en  in  1  1 = wrap at range end; 0 = stop in DONE
sample_tick  in  1  one-cycle pulse at the audio sample rate
flash_read  out  1  Avalon read request
flash_address  out  ADDR_W  Avalon word address
flash_waitrequest  in  1  Avalon waitrequest
flash_readdatavalid  in  1  Avalon readdatavalid
flash_readdata  in  DATA_W  Avalon read data
sample_out  out  SAMPLE_W  current sample, held between updates
sample_valid  out  1  one-cycle pulse when sample_out updates
underrun  out  1  one-cycle pulse when a sample_tick is dropped
done  out  1  high while in DONE
state  out  4  debug encoding of the FSM state

Behaviour:
- Reset applied at clk edge while rst=1; it overrides everything, including an in-flight read. Reset values:
  - state = IDLE, address = START_ADDR, data latch = 0, restart_pending = 0.
  - All outputs 0, except flash_address = START_ADDR.
- State encoding: IDLE=0, REQ=1, WAIT_DATA=2, TICK_A=3, TICK_B=4, DONE=5.
- IDLE: if play=1 -> REQ on the next edge; otherwise stay.
- REQ: flash_read = 1 and flash_address stable, exactly while state==REQ (decoded from the registered state).
  - Exit to WAIT_DATA on the edge where flash_waitrequest=0.
  - play=0 does not abort REQ; the request is held until accepted.
- WAIT_DATA: on flash_readdatavalid=1, latch flash_readdata -> TICK_A.
- TICK_A: on sample_tick & play, output the first half, pulse sample_valid -> TICK_B.
  - Forward: first half = readdata[15:0].
  - Backward: first half = readdata[31:16].
- TICK_B: on sample_tick & play, output the other half, pulse sample_valid, advance the address, then go to IDLE (or DONE).
- sample_valid pulses in the cycle after the accepted tick edge.
- sample_tick while play=0: ignored; no underrun.
- Underrun: sample_tick while play=1 in IDLE, REQ or WAIT_DATA pulses underrun for one cycle. The tick is not queued and sample_out is held.
- Address advance (TICK_B only):
  - Forward: address+1. At END_ADDR it becomes START_ADDR if loop_en=1; otherwise go to DONE with the address unchanged.
  - Backward: address-1. At START_ADDR it becomes END_ADDR if loop_en=1; otherwise go to DONE.
  - dir and loop_en are sampled at the advance edge. A dir change mid-word affects only the next word.
- DONE: done=1, sample_out held, no reads, ticks ignored. Exit only via restart or rst.
- Restart in IDLE, TICK_A, TICK_B or DONE: at the next edge, address = START_ADDR (dir=0) or END_ADDR (dir=1), state -> IDLE.
- Restart in REQ or WAIT_DATA: set restart_pending. The Avalon transaction completes normally, its data is discarded, and the address is reloaded as above -> IDLE. restart_pending clears on that reload.
- Simultaneous restart and the TICK_B advance edge: restart wins; no sample_valid.
- Address arithmetic is ADDR_W-bit; wrap is governed only by the range bounds, never by natural overflow.

Decomposition:
- Shared package flash_audio_pkg:
  - state enum typedef and its 4-bit encoding.
  - Default ADDR_W/SAMPLE_W/DATA_W constants.
  - Default song range constants.
- One natural sub-module: flash_range_counter (up/down bounded counter with load, wrap enable and at_end flag).
- The FSM, data latch and sample mux stay in the top module.

Test Plan:
- Reset then play=1, waitrequest=1 for 3 cycles then 0, readdatavalid returns 32'hBEEF_1234 -> flash_read high 4 cycles at address 0. Two ticks give sample_out 16'h1234 then 16'hBEEF. Next request is at address 1.
- dir=1 after restart, range end 23'h07FFFF, data 32'hAAAA_5555 -> first request at 23'h07FFFF. Samples 16'hAAAA then 16'h5555. Next address 23'h07FFFE.
- Forward at END_ADDR: loop_en=1 -> next address START_ADDR. loop_en=0 -> done=1, no further flash_read, ticks produce no sample_valid.
- Restart pulse during WAIT_DATA -> returned data 32'h1111_2222 is never output. Next request is at START_ADDR.
- play=0 in TICK_A with 5 ticks -> no sample_valid, no underrun. Sample_tick during REQ with play=1 -> one underrun pulse, sample_out unchanged.
- rst asserted during REQ -> next cycle flash_read=0, state=0, flash_address=START_ADDR, all outputs 0.
